// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider:
// default operand width and the controller state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CHECK  = 3'd3,
    S_SUB    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/div_repeated_sub_if.sv
// Request/result bundle of the divider: start and operand bus in,
// quotient, remainder and status out.
interface div_repeated_sub_if import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, data_in,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/div_controller.sv
// Sequencing FSM for the divider: loads both operands over data_in,
// screens for a zero divisor, then subtracts until the remainder is below B.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   S_IDLE   | waiting for start after reset
//   S_LOAD_A | capture dividend into R, clear Q
//   S_LOAD_B | capture divisor into B
//   S_CHECK  | B==0 -> force Q to all-ones and finish with div_by_zero
//   S_SUB    | R>=B: subtract and count; R<B: finish
//   S_DONE   | result held until the next start
module div_controller import div_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic gte,
  input  logic bz,
  output logic ldr,
  output logic ldb,
  output logic clrq,
  output logic subr,
  output logic incq,
  output logic setz,
  output logic busy,
  output logic done,
  output logic div_by_zero
);

  state_t state_q, state_d;
  logic   dz_q;
  logic   accept;

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)
        dz_q <= 1'b0;
      else if (state_q == S_CHECK && bz)
        dz_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ldr     = 1'b0;
    ldb     = 1'b0;
    clrq    = 1'b0;
    subr    = 1'b0;
    incq    = 1'b0;
    setz    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD_A;
      S_LOAD_A: begin
        ldr     = 1'b1;
        clrq    = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        ldb     = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bz) begin
          setz    = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        if (gte) begin
          subr = 1'b1;
          incq = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                       (state_q == S_CHECK)  || (state_q == S_SUB);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dz_q;

endmodule

// File: rtl/div_datapath.sv
// Divider datapath: remainder R, divisor B and quotient Q registers with
// the R>=B comparator, R-B subtractor and Q incrementer.
module div_datapath import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ldr,
  input  logic             ldb,
  input  logic             clrq,
  input  logic             subr,
  input  logic             incq,
  input  logic             setz,
  output logic             gte,
  output logic             bz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] r_q, b_q, q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      b_q <= '0;
      q_q <= '0;
    end else begin
      // subr is only issued when gte holds, so R-B cannot underflow
      if (ldr)
        r_q <= data_in;
      else if (subr)
        r_q <= r_q - b_q;
      if (ldb)
        b_q <= data_in;
      if (clrq)
        q_q <= '0;
      else if (setz)
        q_q <= '1;
      else if (incq)
        q_q <= q_q + WIDTH'(1);
    end
  end

  assign gte       = (r_q >= b_q);
  assign bz        = (b_q == '0);
  assign quotient  = q_q;
  assign remainder = r_q;

endmodule

// File: rtl/div_repeated_sub.sv
// Unsigned repeated-subtraction divider: wires the controller FSM to the
// datapath and exposes them through the request/result interface.
module div_repeated_sub import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  div_repeated_sub_if.slave bus
);

  logic ldr, ldb, clrq, subr, incq, setz;
  logic gte, bz;

  div_controller u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (bus.start),
    .gte         (gte),
    .bz          (bz),
    .ldr         (ldr),
    .ldb         (ldb),
    .clrq        (clrq),
    .subr        (subr),
    .incq        (incq),
    .setz        (setz),
    .busy        (bus.busy),
    .done        (bus.done),
    .div_by_zero (bus.div_by_zero)
  );

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (bus.data_in),
    .ldr       (ldr),
    .ldb       (ldb),
    .clrq      (clrq),
    .subr      (subr),
    .incq      (incq),
    .setz      (setz),
    .gte       (gte),
    .bz        (bz),
    .quotient  (bus.quotient),
    .remainder (bus.remainder)
  );

endmodule

// File: tb/tb_div_repeated_sub.sv
// Self-checking bench for div_repeated_sub: fixed vectors, randomized
// operands against an arithmetic reference, and start/reset corner sequences.
module tb_div_repeated_sub;

  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  div_repeated_sub_if #(.WIDTH(W)) bus ();

  div_repeated_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  // Edges 0..2: start sampled, dividend captured, divisor captured.
  task automatic load(input int a, input int b);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = W'(a);
    @(posedge clk); #1;
    chk("done_low_after_start", 32'(bus.done), 0);
    chk("busy_after_start", 32'(bus.busy), 1);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.data_in = W'(b);
    @(posedge clk);
  endtask

  task automatic wait_done(input bit glitch, output int edges);
    edges = -1;
    for (int n = 3; n < 70000; n++) begin
      @(negedge clk);
      if (glitch && n == 5) begin
        bus.start   = 1'b1;
        bus.data_in = W'(99);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input int a, input int b, input int eq,
                     input int er, input int edz, input int elat, input bit glitch);
    int e;
    load(a, b);
    wait_done(glitch, e);
    chk({tag, "_latency"}, 32'(e), 32'(elat));
    chk({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(edz));
    chk({tag, "_busy_low"}, 32'(bus.busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int a, b, hi, eq, er, edz, elat;

    vecs[0] = '{17, 5, 3, 2, 0, 7};
    vecs[1] = '{5, 17, 0, 5, 0, 4};
    vecs[2] = '{100, 0, 65535, 100, 1, 3};
    vecs[3] = '{0, 9, 0, 0, 0, 4};
    vecs[4] = '{65535, 65535, 1, 0, 0, 5};
    vecs[5] = '{65535, 256, 255, 255, 0, 259};
    vecs[6] = '{65535, 1, 65535, 0, 0, 65539};

    bus.start   = 1'b0;
    bus.data_in = '0;
    #12;
    chk("reset_quotient", 32'(bus.quotient), 0);
    chk("reset_remainder", 32'(bus.remainder), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_dz", 32'(bus.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
          vecs[i].dz, vecs[i].lat, 1'b0);

    // Randomized operands, quotient kept small to bound run time.
    for (int i = 0; i < 20; i++) begin
      b = (i % 7 == 6) ? 0 : int'($urandom_range(1, 65535));
      hi = (b == 0) ? 65535 : b * 41 - 1;
      if (hi > 65535) hi = 65535;
      a = int'($urandom_range(0, hi));
      if (b == 0) begin
        eq = 65535; er = a; edz = 1; elat = 3;
      end else begin
        eq = a / b; er = a % b; edz = 0; elat = 4 + a / b;
      end
      run($sformatf("rand%0d", i), a, b, eq, er, edz, elat, 1'b0);
    end

    // start pulsed mid-SUB is ignored; then start straight out of DONE
    run("glitch", 17, 5, 3, 2, 0, 7, 1'b1);
    run("restart", 20, 4, 5, 0, 0, 9, 1'b0);

    // dz must clear when a normal division follows a divide-by-zero
    run("dz_set", 7, 0, 65535, 7, 1, 3, 1'b0);
    run("dz_clear", 9, 2, 4, 1, 0, 8, 1'b0);

    // asynchronous reset in the middle of SUB
    load(17, 5);
    repeat (3) @(posedge clk);
    #2;
    chk("mid_busy_before_reset", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_quotient", 32'(bus.quotient), 0);
    chk("abort_remainder", 32'(bus.remainder), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_dz", 32'(bus.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("after_reset", 17, 5, 3, 2, 0, 7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
